// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin encoding, coin values, FSM states.
package vend_pkg;

  localparam int unsigned CENTS_W   = 9;
  localparam int unsigned NUM_COINS = 4;

  // Coin index doubles as tube index and as bit position in tube_empty.
  typedef enum logic [1:0] {
    CoinQ = 2'd0,
    CoinD = 2'd1,
    CoinN = 2'd2,
    CoinP = 2'd3
  } coin_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StEject  = 3'd2,
    StGap    = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [CENTS_W-1:0] ValQ = 9'd25;
  localparam logic [CENTS_W-1:0] ValD = 9'd10;
  localparam logic [CENTS_W-1:0] ValN = 9'd5;
  localparam logic [CENTS_W-1:0] ValP = 9'd1;

  function automatic logic [CENTS_W-1:0] coin_value(input coin_e c);
    logic [CENTS_W-1:0] v;
    case (c)
      CoinQ:   v = ValQ;
      CoinD:   v = ValD;
      CoinN:   v = ValN;
      default: v = ValP;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_coin_tube.sv
// One coin tube: saturating refill count, decrement on eject, empty flag.
module vend_coin_tube #(
  parameter int unsigned TUBE_W = 6,
  parameter int unsigned INIT   = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic [TUBE_W-1:0] i_qty,
  input  logic              i_dec,
  output logic              o_empty
);

  logic [TUBE_W-1:0] r_count;
  logic [TUBE_W-1:0] w_count_next;
  logic [TUBE_W:0]   w_sum;

  assign w_sum   = {1'b0, r_count} + {1'b0, i_qty};
  assign o_empty = (r_count == '0);

  // Next count: clamp refills at full scale, never decrement below zero.
  always_comb begin
    w_count_next = r_count;
    if (i_inc) begin
      w_count_next = w_sum[TUBE_W] ? '1 : w_sum[TUBE_W-1:0];
    end
    if (i_dec && (w_count_next != '0)) begin
      w_count_next = w_count_next - TUBE_W'(1);
    end
  end

  // Count register, reloaded with the initial fill on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= TUBE_W'(INIT);
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser: greedy largest-coin payout with solenoid recovery gaps and abort.
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned TUBE_W     = 6,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned INIT_Q     = 20,
  parameter int unsigned INIT_D     = 20,
  parameter int unsigned INIT_N     = 20,
  parameter int unsigned INIT_P     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [8:0]        req_amount,
  output logic              req_ready,
  input  logic              abort,
  input  logic              refill_valid,
  input  logic [1:0]        refill_sel,
  input  logic [TUBE_W-1:0] refill_qty,
  output logic              eject_q,
  output logic              eject_d,
  output logic              eject_n,
  output logic              eject_p,
  output logic              done,
  output logic              shortfall,
  output logic [8:0]        change_left,
  output logic [3:0]        tube_empty
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e               r_state;
  state_e               w_state_next;
  logic [CENTS_W-1:0]   r_remaining;
  logic [CENTS_W-1:0]   w_remaining_next;
  coin_e                r_coin;
  logic [GapW-1:0]      r_gap_cnt;
  logic [CENTS_W-1:0]   r_change_left;
  logic                 r_shortfall;
  logic                 w_shortfall_next;
  logic                 w_found;
  coin_e                w_pick;
  logic [3:0]           w_empty;
  logic [3:0]           w_inc;
  logic [3:0]           w_dec;
  logic                 w_accept;
  logic                 w_gap_last;

  assign w_accept    = req_valid && (r_state == StIdle);
  assign w_gap_last  = (r_gap_cnt == GapW'(GAP_CYCLES - 1));
  assign tube_empty  = w_empty;
  assign change_left = r_change_left;
  assign shortfall   = r_shortfall;
  assign eject_q     = w_dec[CoinQ];
  assign eject_d     = w_dec[CoinD];
  assign eject_n     = w_dec[CoinN];
  assign eject_p     = w_dec[CoinP];

  // Greedy pick: scan smallest to largest so the largest usable coin wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = CoinQ;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!w_empty[i] && (coin_value(coin_e'(i[1:0])) <= r_remaining)) begin
        w_found = 1'b1;
        w_pick  = coin_e'(i[1:0]);
      end
    end
  end

  // Refills only land while idle.
  always_comb begin
    w_inc = '0;
    for (int i = 0; i < 4; i++) begin
      w_inc[i] = (r_state == StIdle) && refill_valid && (refill_sel == i[1:0]);
    end
  end

  vend_coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_Q)) u_tube_q (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_inc[CoinQ]),
    .i_qty   (refill_qty),
    .i_dec   (w_dec[CoinQ]),
    .o_empty (w_empty[CoinQ])
  );

  vend_coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_D)) u_tube_d (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_inc[CoinD]),
    .i_qty   (refill_qty),
    .i_dec   (w_dec[CoinD]),
    .o_empty (w_empty[CoinD])
  );

  vend_coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_N)) u_tube_n (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_inc[CoinN]),
    .i_qty   (refill_qty),
    .i_dec   (w_dec[CoinN]),
    .o_empty (w_empty[CoinN])
  );

  vend_coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_P)) u_tube_p (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_inc[CoinP]),
    .i_qty   (refill_qty),
    .i_dec   (w_dec[CoinP]),
    .o_empty (w_empty[CoinP])
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; abort preempts everything except idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = (req_amount == '0) ? StDone : StSelect;
        end
      end
      StSelect: begin
        if (abort)        w_state_next = StDone;
        else if (w_found) w_state_next = StEject;
        else              w_state_next = StDone;
      end
      StEject: begin
        w_state_next = abort ? StDone : StGap;
      end
      StGap: begin
        if (abort) begin
          w_state_next = StDone;
        end else if (w_gap_last) begin
          w_state_next = (r_remaining != '0) ? StSelect : StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: ready in idle, one eject pulse per EJECT, done pulse in DONE.
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    w_dec     = '0;
    case (r_state)
      StIdle:  req_ready = 1'b1;
      StEject: w_dec[r_coin] = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Remaining balance and shortfall; an eject coinciding with abort still deducts.
  always_comb begin
    w_remaining_next = r_remaining;
    if (w_accept) begin
      w_remaining_next = req_amount;
    end else if (r_state == StEject) begin
      w_remaining_next = r_remaining - coin_value(r_coin);
    end
    w_shortfall_next = (r_state == StSelect) && !abort && !w_found;
  end

  // Datapath registers; result fields latch on entry to DONE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining   <= '0;
      r_coin        <= CoinQ;
      r_gap_cnt     <= '0;
      r_change_left <= '0;
      r_shortfall   <= 1'b0;
    end else begin
      r_remaining <= w_remaining_next;
      if ((r_state == StSelect) && w_found) begin
        r_coin <= w_pick;
      end
      if (r_state == StEject) begin
        r_gap_cnt <= '0;
      end else if (r_state == StGap) begin
        r_gap_cnt <= r_gap_cnt + GapW'(1);
      end
      if (w_state_next == StDone) begin
        r_change_left <= w_remaining_next;
        r_shortfall   <= w_shortfall_next;
      end
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench: expected coin/done events queued at request time, checked as they appear.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_valid;
  logic [8:0] req_amount;
  logic       abort;
  logic [2:0] refill_valid;
  logic [1:0] refill_sel;
  logic [5:0] refill_qty;

  logic [2:0] ready;
  logic [2:0] done;
  logic [2:0] sf;
  logic [3:0] ej    [3];
  logic [8:0] left  [3];
  logic [3:0] empty [3];

  always #5 clk = ~clk;

  // Instance 0: full tubes; 1: no quarters; 2: only two pennies.
  change_dispense_ctrl u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_amount(req_amount),
    .req_ready(ready[0]), .abort(abort), .refill_valid(refill_valid[0]),
    .refill_sel(refill_sel), .refill_qty(refill_qty),
    .eject_q(ej[0][0]), .eject_d(ej[0][1]), .eject_n(ej[0][2]), .eject_p(ej[0][3]),
    .done(done[0]), .shortfall(sf[0]), .change_left(left[0]), .tube_empty(empty[0])
  );

  change_dispense_ctrl #(.INIT_Q(0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_amount(req_amount),
    .req_ready(ready[1]), .abort(abort), .refill_valid(refill_valid[1]),
    .refill_sel(refill_sel), .refill_qty(refill_qty),
    .eject_q(ej[1][0]), .eject_d(ej[1][1]), .eject_n(ej[1][2]), .eject_p(ej[1][3]),
    .done(done[1]), .shortfall(sf[1]), .change_left(left[1]), .tube_empty(empty[1])
  );

  change_dispense_ctrl #(.INIT_Q(0), .INIT_D(0), .INIT_N(0), .INIT_P(2)) u_dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_amount(req_amount),
    .req_ready(ready[2]), .abort(abort), .refill_valid(refill_valid[2]),
    .refill_sel(refill_sel), .refill_qty(refill_qty),
    .eject_q(ej[2][0]), .eject_d(ej[2][1]), .eject_n(ej[2][2]), .eject_p(ej[2][3]),
    .done(done[2]), .shortfall(sf[2]), .change_left(left[2]), .tube_empty(empty[2])
  );

  // kind: 0..3 = coin Q/D/N/P, 4 = done; cyc counts from acceptance (SELECT = 1).
  typedef struct {
    int kind;
    int cyc;
    int left;
    int sf;
  } ev_t;

  ev_t q_exp[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  t_acc    = 0;
  int  sel      = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int l, input int s);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.left = l;
    e.sf   = s;
    q_exp.push_back(e);
  endtask

  // Drive a request (optionally with a refill in the same cycle) to one instance.
  task automatic send_req(input int inst, input int amt, input bit rf, input int rsel,
                          input int rqty);
    @(negedge clk);
    sel = inst;
    check_eq("ready_before_req", int'(ready[inst]), 1);
    req_amount        = 9'(amt);
    req_valid[inst]   = 1'b1;
    refill_valid[inst] = rf;
    refill_sel        = 2'(rsel);
    refill_qty        = 6'(rqty);
    @(posedge clk);
    #1;
    t_acc             = cyc;
    req_valid[inst]   = 1'b0;
    refill_valid[inst] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q_exp.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("drain_timeout", q_exp.size(), 0);
    q_exp.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every eject/done of the selected instance must match the queue head.
  always @(negedge clk) begin
    if (!rst && (ej[sel] != 4'b0 || done[sel])) begin
      int  k;
      ev_t e;
      k = done[sel] ? 4 : 0;
      for (int i = 0; i < 4; i++) if (ej[sel][i]) k = i;
      check_eq("one_hot", $countones({ej[sel], done[sel]}), 1);
      if (q_exp.size() == 0) begin
        check_eq("unexpected_event", k, -1);
      end else begin
        e = q_exp.pop_front();
        check_eq("event_kind", k, e.kind);
        check_eq("event_cycle", cyc - t_acc + 1, e.cyc);
        if (k == 4) begin
          check_eq("change_left", int'(left[sel]), e.left);
          check_eq("shortfall", int'(sf[sel]), e.sf);
        end
      end
    end
  end

  initial begin
    #200000;
    check_eq("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_amount   = '0;
    abort        = 1'b0;
    refill_valid = '0;
    refill_sel   = '0;
    refill_qty   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", int'(ready[0]), 1);
    check_eq("rst_done", int'(done[0]), 0);
    check_eq("rst_left", int'(left[0]), 0);
    check_eq("rst_eject", int'(ej[0]), 0);
    check_eq("rst_empty_a", int'(empty[0]), 0);
    check_eq("rst_empty_c", int'(empty[2]), 4'b0111);
    rst = 1'b0;

    // 65 cents from full tubes: Q,Q,D,N; a refill mid-payout is ignored.
    send_req(0, 65, 1'b0, 0, 0);
    push_ev(0, 2, 0, 0);
    push_ev(0, 6, 0, 0);
    push_ev(1, 10, 0, 0);
    push_ev(2, 14, 0, 0);
    push_ev(4, 17, 0, 0);
    @(negedge clk);
    refill_valid[0] = 1'b1;
    refill_sel      = 2'd0;
    refill_qty      = 6'd5;
    @(negedge clk);
    refill_valid[0] = 1'b0;
    wait_drain();
    check_eq("cnt_q_65", int'(u_dut_a.u_tube_q.r_count), 18);
    check_eq("cnt_d_65", int'(u_dut_a.u_tube_d.r_count), 19);
    check_eq("cnt_n_65", int'(u_dut_a.u_tube_n.r_count), 19);
    check_eq("cnt_p_65", int'(u_dut_a.u_tube_p.r_count), 20);

    // Abort while idle has no effect.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_abort_ready", int'(ready[0]), 1);

    // Zero amount: straight to done.
    send_req(0, 0, 1'b0, 0, 0);
    push_ev(4, 1, 0, 0);
    wait_drain();

    // 100 cents, abort in the second gap: two quarters, 50 left.
    send_req(0, 100, 1'b0, 0, 0);
    push_ev(0, 2, 0, 0);
    push_ev(0, 6, 0, 0);
    push_ev(4, 8, 50, 0);
    do @(negedge clk); while (cyc - t_acc + 1 < 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain();
    check_eq("cnt_q_abort", int'(u_dut_a.u_tube_q.r_count), 16);

    // No quarters: 30 cents as three dimes.
    send_req(1, 30, 1'b0, 0, 0);
    push_ev(1, 2, 0, 0);
    push_ev(1, 6, 0, 0);
    push_ev(1, 10, 0, 0);
    push_ev(4, 13, 0, 0);
    wait_drain();

    // Refill one quarter in the accepting cycle; it is used immediately.
    send_req(1, 25, 1'b1, 0, 1);
    push_ev(0, 2, 0, 0);
    push_ev(4, 5, 0, 0);
    wait_drain();

    // Only two pennies for 4 cents: shortfall of 2.
    send_req(2, 4, 1'b0, 0, 0);
    push_ev(3, 2, 0, 0);
    push_ev(3, 6, 0, 0);
    push_ev(4, 10, 2, 1);
    wait_drain();
    check_eq("empty_c_all", int'(empty[2]), 4'b1111);

    // Reset during the first eject of a 65-cent payout.
    send_req(0, 65, 1'b0, 0, 0);
    push_ev(0, 2, 0, 0);
    do @(negedge clk); while (cyc - t_acc + 1 < 2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_eject", int'(ej[0]), 0);
    check_eq("midrst_done", int'(done[0]), 0);
    check_eq("midrst_left", int'(left[0]), 0);
    check_eq("midrst_sf", int'(sf[0]), 0);
    check_eq("midrst_cnt_q", int'(u_dut_a.u_tube_q.r_count), 20);
    check_eq("midrst_exp_left", q_exp.size(), 0);
    q_exp.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", int'(ready[0]), 1);

    // Saturating refill: 20 + 60 clamps at 63.
    refill_valid[0] = 1'b1;
    refill_sel      = 2'd1;
    refill_qty      = 6'd60;
    @(negedge clk);
    refill_valid[0] = 1'b0;
    check_eq("refill_sat_d", int'(u_dut_a.u_tube_d.r_count), 63);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TUBE_W  6  width of each coin-tube count
  GAP_CYCLES  2  idle cycles between coin ejections (solenoid recovery), minimum 1
  INIT_Q / INIT_D / INIT_N / INIT_P  20 each  tube counts loaded at reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  req_valid  in  1  change request present
  req_amount  in  9  change owed, in cents (0..511)
  req_ready  out  1  block can accept a request
  abort  in  1  stop the current payout
  refill_valid  in  1  tube refill strobe
  refill_sel  in  2  tube select: 0=Q, 1=D, 2=N, 3=P
  refill_qty  in  TUBE_W  coins added
  eject_q / eject_d / eject_n / eject_p  out  1 each  one-cycle coin eject pulses
  done  out  1  one-cycle payout-complete pulse
  shortfall  out  1  payout ended with an unpayable remainder; valid with done
  change_left  out  9  unpaid cents; valid with done
  tube_empty  out  4  per-tube count==0, bit order {P,N,D,Q}

Function
REQ-003 States SHALL be IDLE, SELECT, EJECT, GAP and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid&&req_ready, req_amount is latched into remaining, and the next state is SELECT, or DONE if the amount is 0.
REQ-005 SELECT SHALL last 1 cycle and pick the largest coin in {25,10,5,1} with value<=remaining and count>0; if one is found the next state is EJECT, otherwise DONE with shortfall=1.
REQ-006 EJECT SHALL last 1 cycle, assert exactly one eject_* pulse, decrement that tube count, and subtract the coin value from remaining.
REQ-007 Timing: acceptance at edge k SHALL give SELECT in cycle k+1 and the first eject pulse in cycle k+2.
REQ-008 GAP SHALL last exactly GAP_CYCLES cycles, then go to SELECT if remaining>0, else DONE; consecutive eject pulses are therefore GAP_CYCLES+2 cycles apart.
REQ-009 DONE SHALL last 1 cycle: done=1, change_left=remaining and shortfall as set, then return to IDLE; change_left and shortfall hold their values until the next done.
REQ-010 abort in SELECT, EJECT or GAP SHALL force DONE on the next cycle with change_left=remaining and shortfall=0.
REQ-011 If abort coincides with EJECT, that coin's pulse and decrement SHALL still complete.
REQ-012 abort in IDLE SHALL be ignored.
REQ-013 A refill SHALL be applied only in IDLE; count=min(count+refill_qty, 2^TUBE_W-1) (saturating).
REQ-014 A refill SHALL be ignored in any other state.
REQ-015 A refill and a request accepted in the same IDLE cycle SHALL both apply, with the refilled count visible in the following SELECT.
REQ-016 remaining SHALL never underflow, by construction of REQ-005; tube counts SHALL never wrap.
REQ-017 tube_empty SHALL be combinational from the tube counts.

Reset
REQ-018 rst SHALL asynchronously force: state=IDLE, remaining=0, tube counts=INIT_*, all eject_*=0, done=0, shortfall=0, change_left=0.
REQ-019 rst asserted mid-payout SHALL drop the payout with no completion pulse; coins already ejected stay deducted from nothing, because the counts return to INIT_*.

Structure
REQ-020 Package vend_pkg SHALL hold the coin values (25, 10, 5, 1), the coin-index encoding (0=Q..3=P), the state enum, and the 9-bit cents width constant.
REQ-021 One sub-module, vend_coin_tube, SHALL implement a single saturating up/down count with an empty flag; it is instantiated 4 times.
REQ-022 The selection logic and the FSM SHALL live in change_dispense_ctrl.

Verification
REQ-023 Full tubes, req_amount=65, GAP_CYCLES=2 -> pulses Q,Q,D,N, each 4 cycles apart; done with change_left=0 and shortfall=0; counts Q=18, D=19, N=19.
REQ-024 Q tube refilled to 0 via reset parameter INIT_Q=0, req_amount=30 -> pulses D,D,D; done with shortfall=0.
REQ-025 INIT_Q=INIT_D=INIT_N=0, INIT_P=2, req_amount=4 -> pulses P,P; done with shortfall=1 and change_left=2; tube_empty=4'b1111.
REQ-026 req_amount=0 -> done 1 cycle after acceptance, no eject pulses, change_left=0.
REQ-027 req_amount=100, abort raised during the second GAP -> exactly 2 Q pulses; done next cycle with change_left=50 and shortfall=0.
REQ-028 rst during the first EJECT of a 65-cent payout -> outputs 0 immediately, counts return to INIT_*, req_ready=1 after release; refill of 60 into a tube at 20 (TUBE_W=6) -> count 63.
